// File: rtl/except_arb_if.sv
// except_arb_if
//   Groups every M-stage signal that the exception arbiter exchanges with the
//   pipeline and the CP0 register file.
//   master: the pipeline/CP0 side. It drives slot state and CP0 state, and it
//           receives the arbitration results.
//   slave : the arbiter itself.
//   Signals:
//     stall_masterM, ext_int[5:0]            stage control and raw interrupts
//     valid*, pc*, dslot*                    per-slot instruction state
//     adel_if*, ri*, sys*, brk*, ov*, trap*,
//     eret*, adel_ld*, ades_st*, daddr*      per-slot fault/event flags
//     cp0_we*, cp0_waddr*, cp0_wdata*        same-cycle mtc0 writes
//     status_i, cause_i, epc_i               current CP0 state
//     int_sync_o, excepttype*_o, bad_addr*_o,
//     flush_o, new_pc_o                      arbitration results
interface except_arb_if;
  logic        stall_masterM;
  logic [5:0]  ext_int;
  logic        valid1, valid2;
  logic [31:0] pc1, pc2;
  logic        dslot1, dslot2;
  logic        adel_if1, adel_if2;
  logic        ri1, ri2;
  logic        sys1, sys2;
  logic        brk1, brk2;
  logic        ov1, ov2;
  logic        trap1, trap2;
  logic        eret1, eret2;
  logic        adel_ld1, adel_ld2;
  logic        ades_st1, ades_st2;
  logic [31:0] daddr1, daddr2;
  logic        cp0_we1, cp0_we2;
  logic [4:0]  cp0_waddr1, cp0_waddr2;
  logic [31:0] cp0_wdata1, cp0_wdata2;
  logic [31:0] status_i, cause_i, epc_i;
  logic [5:0]  int_sync_o;
  logic [31:0] excepttype1_o, excepttype2_o;
  logic [31:0] bad_addr1_o, bad_addr2_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output stall_masterM, ext_int, valid1, valid2, pc1, pc2, dslot1, dslot2,
           adel_if1, adel_if2, ri1, ri2, sys1, sys2, brk1, brk2, ov1, ov2,
           trap1, trap2, eret1, eret2, adel_ld1, adel_ld2, ades_st1, ades_st2,
           daddr1, daddr2, cp0_we1, cp0_we2, cp0_waddr1, cp0_waddr2,
           cp0_wdata1, cp0_wdata2, status_i, cause_i, epc_i,
    input  int_sync_o, excepttype1_o, excepttype2_o, bad_addr1_o, bad_addr2_o,
           flush_o, new_pc_o
  );

  modport slave (
    input  stall_masterM, ext_int, valid1, valid2, pc1, pc2, dslot1, dslot2,
           adel_if1, adel_if2, ri1, ri2, sys1, sys2, brk1, brk2, ov1, ov2,
           trap1, trap2, eret1, eret2, adel_ld1, adel_ld2, ades_st1, ades_st2,
           daddr1, daddr2, cp0_we1, cp0_we2, cp0_waddr1, cp0_waddr2,
           cp0_wdata1, cp0_wdata2, status_i, cause_i, epc_i,
    output int_sync_o, excepttype1_o, excepttype2_o, bad_addr1_o, bad_addr2_o,
           flush_o, new_pc_o
  );
endinterface

// File: rtl/except_arb.sv
// except_arb
//   Dual-slot M-stage exception arbiter that feeds CP0. It picks the oldest
//   architectural event, reports its code and faulting address per slot, and
//   then issues a one-cycle registered flush with the redirect PC. The redirect
//   PC is the exception vector, or the EPC for eret. After the flush, M-stage
//   slots are ignored for SQUASH_CYC cycles.
//   Ports:
//     clk  clock
//     rst  synchronous, active-high reset
//     bus  except_arb_if.slave; see the interface for the individual signals
module except_arb #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned SQUASH_CYC = 32'd2
) (
  input  logic         clk,
  input  logic         rst,
  except_arb_if.slave  bus
);

  localparam int unsigned   CW       = (SQUASH_CYC > 32'd1) ? $clog2(SQUASH_CYC) : 32'd1;
  localparam logic [CW-1:0] SQ_LOAD  = CW'(SQUASH_CYC - 32'd1);
  localparam logic [4:0]    EPC_ADDR = 5'd14;
  localparam logic [31:0]   EXC_ERET = 32'h0000000e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } state_t;

  // Returns the event code of one slot, highest priority first.
  function automatic logic [31:0] slot_code(
    input logic take_int, input logic adel_if, input logic ri, input logic ov,
    input logic trap, input logic sys, input logic brk, input logic adel_ld,
    input logic ades_st, input logic eret);
    logic [31:0] c;
    if (take_int)     c = 32'h00000001;
    else if (adel_if) c = 32'h00000004;
    else if (ri)      c = 32'h0000000a;
    else if (ov)      c = 32'h0000000c;
    else if (trap)    c = 32'h0000000d;
    else if (sys)     c = 32'h00000008;
    else if (brk)     c = 32'h00000009;
    else if (adel_ld) c = 32'h00000004;
    else if (ades_st) c = 32'h00000005;
    else if (eret)    c = 32'h0000000e;
    else              c = 32'h00000000;
    return c;
  endfunction

  // Faulting address of the winning event. Decode-class faults that outrank
  // the data faults must hide daddr.
  function automatic logic [31:0] slot_bad(
    input logic take_int, input logic adel_if, input logic hi_fault,
    input logic data_fault, input logic [31:0] pc, input logic [31:0] daddr);
    logic [31:0] b;
    if (take_int)        b = 32'h00000000;
    else if (adel_if)    b = pc;
    else if (hi_fault)   b = 32'h00000000;
    else if (data_fault) b = daddr;
    else                 b = 32'h00000000;
    return b;
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           flush_q, flush_d;
  logic [31:0]    new_pc_q, new_pc_d;
  logic [5:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic           int_pend_q, int_pend_d;

  logic           irq_s, block_s, can_take_s, int_take_s, int1_s, int2_s;
  logic [31:0]    code1_s, code2_s, bad1_s, bad2_s;
  logic [31:0]    et1_s, et2_s, ba1_s, ba2_s;
  logic [31:0]    epc1_s, epc2_s, sel_code_s, sel_epc_s, redirect_pc_s;
  logic           report_s;
  logic           unused_s;

  // Decode the interrupt request, then the per-slot codes and the slot ordering.
  always_comb begin
    irq_s = (|(bus.cause_i[15:8] & bus.status_i[15:8])) & bus.status_i[0] & ~bus.status_i[1];
    block_s    = rst | bus.stall_masterM | (state_q == ST_SQUASH);
    can_take_s = ~block_s & (bus.valid1 | bus.valid2);
    int_take_s = irq_s & can_take_s;
    // The interrupt attaches to the oldest valid slot only.
    int1_s = int_take_s & bus.valid1;
    int2_s = int_take_s & ~bus.valid1;

    code1_s = slot_code(int1_s, bus.adel_if1, bus.ri1, bus.ov1, bus.trap1, bus.sys1,
                        bus.brk1, bus.adel_ld1, bus.ades_st1, bus.eret1);
    code2_s = slot_code(int2_s, bus.adel_if2, bus.ri2, bus.ov2, bus.trap2, bus.sys2,
                        bus.brk2, bus.adel_ld2, bus.ades_st2, bus.eret2);
    bad1_s  = slot_bad(int1_s, bus.adel_if1,
                       bus.ri1 | bus.ov1 | bus.trap1 | bus.sys1 | bus.brk1,
                       bus.adel_ld1 | bus.ades_st1, bus.pc1, bus.daddr1);
    bad2_s  = slot_bad(int2_s, bus.adel_if2,
                       bus.ri2 | bus.ov2 | bus.trap2 | bus.sys2 | bus.brk2,
                       bus.adel_ld2 | bus.ades_st2, bus.pc2, bus.daddr2);

    if (block_s | ~bus.valid1) begin
      et1_s = 32'h00000000;
      ba1_s = 32'h00000000;
    end else begin
      et1_s = code1_s;
      ba1_s = bad1_s;
    end

    // An event on the older slot kills the younger slot's report.
    if (block_s | ~bus.valid2 | (et1_s != 32'h00000000)) begin
      et2_s = 32'h00000000;
      ba2_s = 32'h00000000;
    end else begin
      et2_s = code2_s;
      ba2_s = bad2_s;
    end
  end

  // Forward same-cycle EPC writes and pick the redirect target of the winner.
  always_comb begin
    if (bus.cp0_we1 && (bus.cp0_waddr1 == EPC_ADDR)) begin
      epc1_s = bus.cp0_wdata1;
    end else begin
      epc1_s = bus.epc_i;
    end
    // Slot2 sees its own write first, then the older slot1 write.
    if (bus.cp0_we2 && (bus.cp0_waddr2 == EPC_ADDR)) begin
      epc2_s = bus.cp0_wdata2;
    end else begin
      epc2_s = epc1_s;
    end

    if (et1_s != 32'h00000000) begin
      report_s   = 1'b1;
      sel_code_s = et1_s;
      sel_epc_s  = epc1_s;
    end else if (et2_s != 32'h00000000) begin
      report_s   = 1'b1;
      sel_code_s = et2_s;
      sel_epc_s  = epc2_s;
    end else begin
      report_s   = 1'b0;
      sel_code_s = 32'h00000000;
      sel_epc_s  = bus.epc_i;
    end

    if (sel_code_s == EXC_ERET) begin
      redirect_pc_s = sel_epc_s;
    end else begin
      redirect_pc_s = EXC_VECTOR;
    end
  end

  // Next-state logic for the redirect FSM, the synchroniser and the pending interrupt.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    sync1_d  = bus.ext_int;
    sync2_d  = sync1_q;

    case (state_q)
      ST_IDLE: begin
        if (report_s) begin
          state_d  = ST_REDIRECT;
          flush_d  = 1'b1;
          new_pc_d = redirect_pc_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_SQUASH;
        cnt_d   = SQ_LOAD;
      end
      ST_SQUASH: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    if (~irq_s) begin
      int_pend_d = 1'b0;
    end else if (int_take_s) begin
      int_pend_d = 1'b0;
    end else if (~can_take_s) begin
      int_pend_d = 1'b1;
    end else begin
      int_pend_d = int_pend_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      flush_q    <= 1'b0;
      new_pc_q   <= 32'h00000000;
      sync1_q    <= 6'd0;
      sync2_q    <= 6'd0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      new_pc_q   <= new_pc_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      int_pend_q <= int_pend_d;
    end
  end

  // rst gates the flush immediately. It must not wait for the next edge to clear flush_q.
  assign bus.flush_o       = flush_q & ~rst;
  assign bus.new_pc_o      = new_pc_q;
  assign bus.int_sync_o    = sync2_q;
  assign bus.excepttype1_o = et1_s;
  assign bus.excepttype2_o = et2_s;
  assign bus.bad_addr1_o   = ba1_s;
  assign bus.bad_addr2_o   = ba2_s;

  // Delay-slot flags travel to CP0 on a separate path; the unused CP0 bits are not decoded here.
  assign unused_s = ^{bus.dslot1, bus.dslot2, bus.status_i[31:16], bus.status_i[7:2],
                      bus.cause_i[31:16], bus.cause_i[7:0]};

endmodule

// File: tb/tb_except_arb.sv
// tb_except_arb
//   Directed bench for except_arb. It drives the interface from one linear
//   initial block and checks each point with an immediate assertion against
//   hand-derived values. cause_i is modelled as CP0 would present it: the
//   synchronised hardware interrupts appear in IP[7:2].
module tb_except_arb;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  except_arb_if bus ();

  except_arb #(
    .EXC_VECTOR (32'hBFC00380),
    .SQUASH_CYC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.cause_i = {16'h0000, bus.int_sync_o, 10'h000};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.stall_masterM = 1'b0; bus.ext_int = 6'd0;
    bus.valid1 = 1'b0; bus.valid2 = 1'b0;
    bus.pc1 = 32'h0; bus.pc2 = 32'h0; bus.dslot1 = 1'b0; bus.dslot2 = 1'b0;
    bus.adel_if1 = 1'b0; bus.adel_if2 = 1'b0; bus.ri1 = 1'b0; bus.ri2 = 1'b0;
    bus.sys1 = 1'b0; bus.sys2 = 1'b0; bus.brk1 = 1'b0; bus.brk2 = 1'b0;
    bus.ov1 = 1'b0; bus.ov2 = 1'b0; bus.trap1 = 1'b0; bus.trap2 = 1'b0;
    bus.eret1 = 1'b0; bus.eret2 = 1'b0; bus.adel_ld1 = 1'b0; bus.adel_ld2 = 1'b0;
    bus.ades_st1 = 1'b0; bus.ades_st2 = 1'b0; bus.daddr1 = 32'h0; bus.daddr2 = 32'h0;
    bus.cp0_we1 = 1'b0; bus.cp0_we2 = 1'b0; bus.cp0_waddr1 = 5'd0; bus.cp0_waddr2 = 5'd0;
    bus.cp0_wdata1 = 32'h0; bus.cp0_wdata2 = 32'h0;
    bus.status_i = 32'h0; bus.epc_i = 32'h0;
  endtask

  // Clear the inputs, then give any redirect/squash sequence time to finish back in IDLE.
  task automatic drain();
    clear();
    repeat (4) tick();
  endtask

  initial begin
    clear();
    rst = 1'b1;
    tick();
    tick();
    // Reset: outputs forced low even with a live fault.
    bus.valid1 = 1'b1; bus.sys1 = 1'b1;
    #1;
    chk("rst_et1", bus.excepttype1_o, 32'h0);
    chk("rst_flush", {31'd0, bus.flush_o}, 32'h0);
    chk("rst_newpc", bus.new_pc_o, 32'h0);
    chk("rst_intsync", {26'd0, bus.int_sync_o}, 32'h0);
    tick();
    rst = 1'b0;
    clear();
    tick();

    // syscall on slot1, then the flush and a 2-cycle squash.
    bus.valid1 = 1'b1; bus.sys1 = 1'b1; bus.pc1 = 32'h80001000;
    #1;
    chk("sys_et1", bus.excepttype1_o, 32'h8);
    chk("sys_et2", bus.excepttype2_o, 32'h0);
    chk("sys_bad1", bus.bad_addr1_o, 32'h0);
    tick();
    bus.sys1 = 1'b0; bus.valid2 = 1'b1; bus.ri2 = 1'b1;
    #1;
    chk("sys_flush", {31'd0, bus.flush_o}, 32'h1);
    chk("sys_newpc", bus.new_pc_o, 32'hBFC00380);
    tick();
    chk("sq1_et2", bus.excepttype2_o, 32'h0);
    chk("sq1_flush", {31'd0, bus.flush_o}, 32'h0);
    tick();
    chk("sq2_et2", bus.excepttype2_o, 32'h0);
    tick();
    chk("post_sq_et2", bus.excepttype2_o, 32'ha);
    drain();

    // Store misalignment on slot2 behind a clean slot1.
    bus.valid1 = 1'b1; bus.valid2 = 1'b1; bus.ades_st2 = 1'b1; bus.daddr2 = 32'h80000003;
    #1;
    chk("ades_et1", bus.excepttype1_o, 32'h0);
    chk("ades_et2", bus.excepttype2_o, 32'h5);
    chk("ades_bad2", bus.bad_addr2_o, 32'h80000003);
    drain();

    // Fetch AdEL outranks Ov; slot1 event hides slot2 syscall.
    bus.valid1 = 1'b1; bus.adel_if1 = 1'b1; bus.ov1 = 1'b1; bus.pc1 = 32'h80000002;
    bus.valid2 = 1'b1; bus.sys2 = 1'b1;
    #1;
    chk("adelif_et1", bus.excepttype1_o, 32'h4);
    chk("adelif_bad1", bus.bad_addr1_o, 32'h80000002);
    chk("adelif_et2", bus.excepttype2_o, 32'h0);
    drain();

    // RI outranks load AdEL, and the data address is not reported.
    bus.valid1 = 1'b1; bus.ri1 = 1'b1; bus.adel_ld1 = 1'b1; bus.daddr1 = 32'h80000001;
    #1;
    chk("ri_ld_et1", bus.excepttype1_o, 32'ha);
    chk("ri_ld_bad1", bus.bad_addr1_o, 32'h0);
    drain();

    // Invalid slots report nothing.
    bus.sys1 = 1'b1; bus.sys2 = 1'b1;
    #1;
    chk("inv_et1", bus.excepttype1_o, 32'h0);
    chk("inv_et2", bus.excepttype2_o, 32'h0);
    drain();

    // Interrupt arriving with no valid slot becomes pending, then lands on slot2.
    bus.status_i = 32'h0000FF01; bus.ext_int = 6'h01;
    tick();
    chk("int_sync_lag1", {26'd0, bus.int_sync_o}, 32'h0);
    tick();
    chk("int_sync_lag2", {26'd0, bus.int_sync_o}, 32'h1);
    tick();
    chk("int_pend_set", {31'd0, dut.int_pend_q}, 32'h1);
    bus.valid2 = 1'b1; bus.ri2 = 1'b1;
    #1;
    chk("int_et2", bus.excepttype2_o, 32'h1);
    chk("int_et1", bus.excepttype1_o, 32'h0);
    chk("int_bad2", bus.bad_addr2_o, 32'h0);
    tick();
    chk("int_flush", {31'd0, bus.flush_o}, 32'h1);
    chk("int_newpc", bus.new_pc_o, 32'hBFC00380);
    chk("int_pend_clr", {31'd0, dut.int_pend_q}, 32'h0);
    drain();

    // eret on slot2, with the EPC written by an mtc0 in slot1 in the same cycle.
    bus.valid1 = 1'b1; bus.cp0_we1 = 1'b1; bus.cp0_waddr1 = 5'd14; bus.cp0_wdata1 = 32'h80002000;
    bus.valid2 = 1'b1; bus.eret2 = 1'b1; bus.epc_i = 32'h12345678;
    #1;
    chk("eret_fwd_et2", bus.excepttype2_o, 32'he);
    tick();
    chk("eret_fwd_newpc", bus.new_pc_o, 32'h80002000);
    drain();

    // A younger EPC write must not reach an eret in slot1.
    bus.valid1 = 1'b1; bus.eret1 = 1'b1; bus.epc_i = 32'h80003000;
    bus.valid2 = 1'b1; bus.cp0_we2 = 1'b1; bus.cp0_waddr2 = 5'd14; bus.cp0_wdata2 = 32'h00000009;
    #1;
    chk("eret1_et1", bus.excepttype1_o, 32'he);
    tick();
    chk("eret1_newpc", bus.new_pc_o, 32'h80003000);
    drain();

    // Stall holds off the syscall for 3 cycles.
    bus.stall_masterM = 1'b1; bus.valid1 = 1'b1; bus.sys1 = 1'b1;
    #1;
    chk("stall_et1_0", bus.excepttype1_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flush", {31'd0, bus.flush_o}, 32'h0);
      chk("stall_et1", bus.excepttype1_o, 32'h0);
    end
    bus.stall_masterM = 1'b0;
    #1;
    chk("unstall_et1", bus.excepttype1_o, 32'h8);
    tick();
    chk("unstall_flush", {31'd0, bus.flush_o}, 32'h1);
    chk("unstall_newpc", bus.new_pc_o, 32'hBFC00380);
    drain();

    // Reset asserted during the REDIRECT cycle.
    bus.valid1 = 1'b1; bus.sys1 = 1'b1;
    tick();
    chk("pre_rst_flush", {31'd0, bus.flush_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_flush", {31'd0, bus.flush_o}, 32'h0);
    tick();
    rst = 1'b0;
    clear();
    #1;
    chk("post_rst_state", 32'(dut.state_q), 32'h0);
    chk("post_rst_flush", {31'd0, bus.flush_o}, 32'h0);
    chk("post_rst_newpc", bus.new_pc_o, 32'h0);
    bus.valid1 = 1'b1; bus.brk1 = 1'b1;
    #1;
    chk("post_rst_et1", bus.excepttype1_o, 32'h9);
    tick();
    chk("post_rst_flush2", {31'd0, bus.flush_o}, 32'h1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
